// File: rtl/axis_gpio_pkg.sv
// Shared definitions for the ASCII command-to-GPIO parser.
//   ASCII_CR / ASCII_LF : the two line terminators
//   parse_state_e       : parser states (PREFIX, DIGITS, EOL_WAIT, DISCARD)
//   hex_nibble()        : ASCII byte -> {valid, nibble[3:0]}, case-insensitive
package axis_gpio_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        PREFIX   = 2'd0,
        DIGITS   = 2'd1,
        EOL_WAIT = 2'd2,
        DISCARD  = 2'd3
    } parse_state_e;

    // Bit 4 flags a valid hex character; bits 3:0 hold its value.
    // Letters: low nibble of 'A'/'a' is 1, so adding 9 yields 10.
    function automatic logic [4:0] hex_nibble(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            r = {1'b1, b[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier for one ASCII byte.
//   byte_i    : incoming character
//   is_hex_o  : byte is [0-9A-Fa-f]
//   nibble_o  : value of the hex digit (0 when not hex)
//   is_eol_o  : byte is CR or LF
module ascii_hex_decode
    import axis_gpio_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o,
    output logic       is_eol_o
);

    logic [4:0] hex_w;

    assign hex_w    = hex_nibble(byte_i);
    assign is_hex_o = hex_w[4];
    assign nibble_o = hex_w[3:0];
    assign is_eol_o = (byte_i == ASCII_CR) || (byte_i == ASCII_LF);

endmodule

// File: rtl/axis_cmd_gpio.sv
// AXI-Stream slave that parses "LED=0xHHHH<CR|LF>" text lines and drives the
// decoded value on a registered GPIO bus. Malformed lines are dropped and
// counted without touching the GPIO outputs.
//   s00_axis_aclk / s00_axis_aresetn : clock, async active-low reset
//   s00_axis_tdata/tvalid/tlast      : byte stream input
//   s00_axis_tready                  : registered, 1 from the first clock after reset
//   gpio_out                         : last committed value
//   cmd_done / cmd_err               : 1-cycle pulses for commit / rejected line
//   err_count                        : saturating count of rejected lines
// Handshake: a byte is consumed on a rising edge where tvalid & tready are both
// high; tready never drops after reset, so every beat completes in one cycle.
// tlast acts as an implicit end-of-line after the byte's own effect.
module axis_cmd_gpio
    import axis_gpio_pkg::*;
#(
    parameter int                        PREFIX_CHARS  = 6,
    parameter logic [8*PREFIX_CHARS-1:0] PREFIX_STRING = "LED=0x",
    parameter int                        GPIO_WIDTH    = 16,
    parameter logic [GPIO_WIDTH-1:0]     GPIO_INIT     = '0,
    parameter int                        AXI_WIDTH     = 8
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic [AXI_WIDTH-1:0]  s00_axis_tdata,
    input  logic                  s00_axis_tvalid,
    input  logic                  s00_axis_tlast,
    output logic                  s00_axis_tready,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  cmd_done,
    output logic                  cmd_err,
    output logic [7:0]            err_count
);

    localparam int HEX_DIGITS = (GPIO_WIDTH + 3) / 4;
    localparam int ACC_W      = 4 * HEX_DIGITS;
    localparam int IDX_W      = $clog2(PREFIX_CHARS + 1);
    localparam int CNT_W      = $clog2(HEX_DIGITS + 1);

    parse_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [GPIO_WIDTH-1:0] gpio_q;
    logic                  done_q, err_q, tready_q;
    logic [7:0]            err_cnt_q;

    logic       beat, commit, err;
    logic [7:0] byte_w, prefix_char;
    logic       is_hex, is_eol;
    logic [3:0] nibble;

    assign byte_w = s00_axis_tdata[7:0];
    assign beat   = s00_axis_tvalid & tready_q;

    ascii_hex_decode u_dec (
        .byte_i   (byte_w),
        .is_hex_o (is_hex),
        .nibble_o (nibble),
        .is_eol_o (is_eol)
    );

    // First prefix character lives in the most significant byte.
    assign prefix_char = PREFIX_STRING[8*(PREFIX_CHARS-1-int'(idx_q)) +: 8];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        commit  = 1'b0;
        err     = 1'b0;
        if (beat) begin
            case (state_q)
                PREFIX: begin
                    if (byte_w == prefix_char) begin
                        if (idx_q == IDX_W'(PREFIX_CHARS - 1)) begin
                            state_d = DIGITS;
                            idx_d   = '0;
                            cnt_d   = '0;
                            acc_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                        // Packet ended part-way through a command line.
                        if (s00_axis_tlast) begin
                            err     = 1'b1;
                            state_d = PREFIX;
                            idx_d   = '0;
                        end
                    end else if (is_eol && idx_q == '0) begin
                        // Blank line or second half of CRLF: nothing to do.
                        state_d = PREFIX;
                    end else begin
                        err     = 1'b1;
                        idx_d   = '0;
                        state_d = (is_eol || s00_axis_tlast) ? PREFIX : DISCARD;
                    end
                end
                DIGITS: begin
                    if (is_hex) begin
                        acc_d = {acc_q[ACC_W-5:0], nibble};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(HEX_DIGITS - 1)) begin
                            if (s00_axis_tlast) begin
                                commit  = 1'b1;
                                state_d = PREFIX;
                            end else begin
                                state_d = EOL_WAIT;
                            end
                        end else if (s00_axis_tlast) begin
                            err     = 1'b1;
                            state_d = PREFIX;
                        end
                    end else begin
                        err     = 1'b1;
                        state_d = (is_eol || s00_axis_tlast) ? PREFIX : DISCARD;
                    end
                end
                EOL_WAIT: begin
                    if (is_eol) begin
                        commit  = 1'b1;
                        state_d = PREFIX;
                    end else begin
                        err     = 1'b1;
                        state_d = s00_axis_tlast ? PREFIX : DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_eol || s00_axis_tlast) begin
                        state_d = PREFIX;
                    end
                end
                default: begin
                    state_d = PREFIX;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q   <= PREFIX;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            gpio_q    <= GPIO_INIT;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            tready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            tready_q <= 1'b1;
            done_q   <= commit;
            err_q    <= err;
            // acc_d already includes the final digit when tlast commits.
            if (commit) begin
                gpio_q <= acc_d[GPIO_WIDTH-1:0];
            end
            if (err && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign s00_axis_tready = tready_q;
    assign gpio_out        = gpio_q;
    assign cmd_done        = done_q;
    assign cmd_err         = err_q;
    assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_axis_cmd_gpio.sv
// Bench for axis_cmd_gpio. The reference model works one whole line at a time:
// a line is either "LED=0x" followed by exactly four hex digits (commit) or, if
// non-empty, rejected; empty lines are ignored.
module tb_axis_cmd_gpio;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tdata = 8'd0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic [15:0] gpio;
    logic        cmd_done, cmd_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    axis_cmd_gpio dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tdata   (tdata),
        .s00_axis_tvalid  (tvalid),
        .s00_axis_tlast   (tlast),
        .s00_axis_tready  (tready),
        .gpio_out         (gpio),
        .cmd_done         (cmd_done),
        .cmd_err          (cmd_err),
        .err_count        (err_count)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  line_q[$];
    int          exp_err = 0;
    int          exp_pulses = 0;
    int          err_pulses = 0;
    logic [15:0] prev_gpio = 16'h0000;

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    task automatic finish_line();
        string pfx;
        bit    ok;
        int    value;
        int    d;
        pfx = "LED=0x";
        if (line_q.size() == 0) return;
        ok = (line_q.size() == 10);
        value = 0;
        if (ok) begin
            for (int i = 0; i < 6; i++) if (line_q[i] != pfx[i]) ok = 0;
            for (int i = 6; i < 10; i++) begin
                d = hexval(line_q[i]);
                if (d < 0) ok = 0;
                else value = value * 16 + d;
            end
        end
        if (ok) begin
            exp_q.push_back(value[15:0]);
        end else begin
            exp_pulses++;
            if (exp_err < 255) exp_err++;
        end
        line_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit last);
        if (b == 8'h0D || b == 8'h0A) begin
            finish_line();
        end else begin
            line_q.push_back(b);
            if (last) finish_line();
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (rst_n) begin
            checks++;
            if (cmd_done && cmd_err) begin
                failures++;
                $display("FAIL done_err_overlap: cmd_done=%b cmd_err=%b required not both", cmd_done, cmd_err);
            end
            if (cmd_err) err_pulses++;
            checks++;
            if (cmd_done) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: gpio=%h with no command expected", gpio);
                end else begin
                    e = exp_q.pop_front();
                    if (gpio !== e) begin
                        failures++;
                        $display("FAIL commit_value: gpio=%h required %h", gpio, e);
                    end
                end
            end else if (gpio !== prev_gpio) begin
                failures++;
                $display("FAIL gpio_stable: gpio=%h required %h (no cmd_done)", gpio, prev_gpio);
            end
            prev_gpio = gpio;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
        int n;
        int w;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                tvalid = 1'b0;
                tdata  = 8'($urandom);
                tlast  = 1'($urandom);
                tick();
            end
        end
        tvalid = 1'b1;
        tdata  = b;
        tlast  = last;
        w = 0;
        while (!tready && w < 10) begin
            tick();
            w++;
        end
        if (!tready) begin
            checks++;
            failures++;
            $display("FAIL tready_timeout: tready=%b required 1", tready);
        end
        model_byte(b, last);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_final, input bit gaps);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_final && (i == s.len() - 1), gaps);
    endtask

    task automatic drain(input string name);
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending: %0d commits missing required 0", name, exp_q.size());
        end
        checks++;
        if (err_pulses != exp_pulses) begin
            failures++;
            $display("FAIL %s_err_pulses: got %0d required %0d", name, err_pulses, exp_pulses);
        end
        checks++;
        if (err_count !== 8'(exp_err)) begin
            failures++;
            $display("FAIL %s_err_count: got %0d required %0d", name, err_count, exp_err);
        end
    endtask

    task automatic check_gpio(input string name, input logic [15:0] e);
        checks++;
        if (gpio !== e) begin
            failures++;
            $display("FAIL %s: gpio=%h required %h", name, gpio, e);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        tvalid = 1'b0;
        #2;
        checks += 5;
        if (gpio !== 16'h0000) begin failures++; $display("FAIL reset_gpio: %h required 0000", gpio); end
        if (tready !== 1'b0) begin failures++; $display("FAIL reset_tready: %b required 0", tready); end
        if (cmd_done !== 1'b0) begin failures++; $display("FAIL reset_done: %b required 0", cmd_done); end
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_err: %b required 0", cmd_err); end
        if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count: %0d required 0", err_count); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (tready !== 1'b0) begin failures++; $display("FAIL tready_before_edge: %b required 0", tready); end
        tick();
        checks++;
        if (tready !== 1'b1) begin failures++; $display("FAIL tready_after_release: %b required 1", tready); end
    endtask

    task automatic test_basic();
        send_str("LED=0xA5C3", 1'b0, 1'b0);
        send_byte(8'h0D, 1'b0, 1'b0);
        check_gpio("basic_gpio_after_cr", 16'hA5C3);
        checks++;
        if (cmd_done !== 1'b1) begin failures++; $display("FAIL basic_done: %b required 1", cmd_done); end
        send_byte(8'h0A, 1'b0, 1'b0);
        checks++;
        if (cmd_done !== 1'b0) begin failures++; $display("FAIL basic_done_width: %b required 0", cmd_done); end
        drain("basic");
    endtask

    task automatic test_back_to_back();
        send_str("LED=0x00ff", 1'b0, 1'b1);
        send_byte(8'h0A, 1'b0, 1'b1);
        send_str("LED=0x1234", 1'b0, 1'b1);
        send_byte(8'h0D, 1'b0, 1'b1);
        drain("b2b");
        check_gpio("b2b_final", 16'h1234);
    endtask

    task automatic test_bad_digit();
        send_str("LED=0x12G4", 1'b0, 1'b0);
        send_byte(8'h0D, 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        drain("bad_digit");
        check_gpio("bad_digit_hold", 16'h1234);
        send_str("LED=0xBEEF", 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        drain("after_bad");
        check_gpio("after_bad_gpio", 16'hBEEF);
    endtask

    task automatic test_malformed();
        send_str("LXD=0x1111", 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        send_str("LED=0x123", 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        send_str("LED=0x12345", 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        drain("malformed");
        check_gpio("malformed_hold", 16'hBEEF);
    endtask

    task automatic test_tlast();
        send_str("LED=0x0F0F", 1'b1, 1'b0);
        drain("tlast_commit");
        check_gpio("tlast_commit_gpio", 16'h0F0F);
        send_str("LED=0x0", 1'b1, 1'b0);
        send_str("LED=0x4242", 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        drain("tlast_short");
        check_gpio("tlast_recover", 16'h4242);
    endtask

    task automatic test_random();
        logic [7:0]  bq[$];
        logic [15:0] v;
        int          kind, term, pos;
        string       pfx;
        logic [7:0]  c;
        pfx = "LED=0x";
        for (int n = 0; n < 40; n++) begin
            bq.delete();
            v = 16'($urandom);
            kind = $urandom_range(0, 6);
            for (int i = 0; i < 6; i++) bq.push_back(pfx[i]);
            for (int i = 3; i >= 0; i--) begin
                c = (v[4*i +: 4] < 4'd10) ? 8'h30 + 8'(v[4*i +: 4]) : 8'h37 + 8'(v[4*i +: 4]);
                if (c >= 8'h41 && $urandom_range(0, 1) == 1) c = c + 8'h20;
                bq.push_back(c);
            end
            pos = $urandom_range(0, 5);
            case (kind)
                3: bq[6 + pos % 4] = (pos % 2 == 0) ? 8'h47 : 8'h20;
                4: void'(bq.pop_back());
                5: bq.push_back(8'h37);
                6: bq[pos] = bq[pos] ^ 8'h20;
                default: ;
            endcase
            term = $urandom_range(0, 3);
            for (int i = 0; i < bq.size(); i++)
                send_byte(bq[i], (term == 3) && (i == bq.size() - 1), 1'b1);
            if (term == 0 || term == 2) send_byte(8'h0D, 1'b0, 1'b1);
            if (term == 1 || term == 2) send_byte(8'h0A, 1'b0, 1'b1);
        end
        drain("random");
    endtask

    task automatic test_saturation();
        repeat (252) begin
            send_byte(8'h58, 1'b0, 1'b0);
            send_byte(8'h0A, 1'b0, 1'b0);
        end
        drain("saturation");
    endtask

    task automatic test_reset_midline();
        send_str("LED=0x12", 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (gpio !== 16'h0000) begin failures++; $display("FAIL midreset_gpio: %h required 0000", gpio); end
        if (tready !== 1'b0) begin failures++; $display("FAIL midreset_tready: %b required 0", tready); end
        if (err_count !== 8'd0) begin failures++; $display("FAIL midreset_err_count: %0d required 0", err_count); end
        line_q.delete();
        exp_q.delete();
        exp_err = 0;
        exp_pulses = 0;
        err_pulses = 0;
        prev_gpio = 16'h0000;
        repeat (2) tick();
        rst_n = 1'b1;
        send_str("LED=0x8001", 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        drain("midreset");
        check_gpio("midreset_recover", 16'h8001);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_digit();
        test_malformed();
        test_tlast();
        test_random();
        test_saturation();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
